// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, FSM encodings, key type
// and the GF(2^8) helpers that build the S-box and round constants.
// Pure declarations; no clocked logic lives here.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box computed as affine(x^254); x^254 is the field inverse and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for rounds 1..10; anything else yields zero
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_gen.sv
// One AES-128 key-expansion round: previous round key in, next round key out.
// Purely combinational (zero latency); four S-box lookups plus the round constant.
// No handshake; the caller registers the result.
module key_gen
  import aes_pkg::*;
(
  input  logic [3:0] rnd_idx,
  input  key_t       key_in,
  output key_t       key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, temp;
  logic [31:0] n0, n1, n2, n3;

  // RotWord/SubWord/Rcon on the last word, then the xor chain across the key
  always_comb begin
    w0    = key_in[127:96];
    w1    = key_in[95:64];
    w2    = key_in[63:32];
    w3    = key_in[31:0];
    rot_w = {w3[23:0], w3[31:24]};
    temp  = {sbox(rot_w[31:24]) ^ rcon(rnd_idx), sbox(rot_w[23:16]),
             sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    n0    = w0 ^ temp;
    n1    = w1 ^ n0;
    n2    = w2 ^ n1;
    n3    = w3 ^ n2;
    key_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Expands an AES-128 key into NR+1 round keys, one round per clock, and serves them by index.
// Latency: rk[r] written r cycles after key accept, done/keys_valid after NR; reads return in 1 cycle.
// Backpressure: key_ready low while expanding (source holds key_valid); reads are never stalled.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             clear,
  output logic             busy,
  output logic             keys_valid,
  output logic             done,
  input  logic             rk_req,
  input  logic [IDX_W-1:0] rk_idx,
  output logic             rk_rvalid,
  output logic [127:0]     rk_data,
  output logic             rk_err
);

  state_t           state_q;
  logic [IDX_W-1:0] rnd_q;
  key_t             cur_q;
  key_t             rk_q [0:NR];
  logic             key_ready_q, busy_q, keys_valid_q, done_q;
  logic             rk_rvalid_q, rk_err_q;
  key_t             rk_data_q;

  key_t             next_key;
  logic             accept, expand_we, rd_ok;
  key_t             rd_data_d;

  key_gen u_key_gen (
    .rnd_idx (rnd_q),
    .key_in  (cur_q),
    .key_out (next_key)
  );

  // clear outranks both a new key and an in-flight round write
  assign accept    = !clear && key_ready_q && key_valid;
  assign expand_we = !clear && (state_q == ST_EXPAND);

  // Control FSM: sequences rounds 1..NR and owns all status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rnd_q        <= '0;
      cur_q        <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear) begin
      // Stored keys stay in place but are no longer advertised as valid
      state_q      <= ST_IDLE;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (key_valid && key_ready_q) begin
            state_q      <= ST_EXPAND;
            cur_q        <= key_in;
            rnd_q        <= IDX_W'(1);
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        ST_EXPAND: begin
          cur_q <= next_key;
          if (rnd_q == IDX_W'(NR)) begin
            // Counter parks at NR so it never wraps
            state_q      <= ST_READY;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            rnd_q <= rnd_q + IDX_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Round-key register file: slot 0 on accept, slot rnd during expansion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      if (accept) rk_q[0] <= key_in;
      if (expand_we) begin
        for (int i = 1; i <= NR; i++) begin
          if (rnd_q == IDX_W'(i)) rk_q[i] <= next_key;
        end
      end
    end
  end

  // Read qualification and index mux; a slot being written this cycle is not yet readable
  always_comb begin
    rd_ok = (rk_idx <= IDX_W'(NR)) &&
            (keys_valid_q || ((state_q == ST_EXPAND) && (rk_idx < rnd_q)));
    rd_data_d = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_idx == IDX_W'(i)) rd_data_d = rk_q[i];
    end
  end

  // Registered read response, one cycle after every request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_rvalid_q <= 1'b0;
      rk_err_q    <= 1'b0;
      rk_data_q   <= '0;
    end else begin
      rk_rvalid_q <= rk_req;
      rk_err_q    <= rk_req && !rd_ok;
      rk_data_q   <= (rk_req && rd_ok) ? rd_data_d : '0;
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign done       = done_q;
  assign rk_rvalid  = rk_rvalid_q;
  assign rk_err     = rk_err_q;
  assign rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: FIPS-197 and all-zero key vectors,
// read scoreboard with exact 1-cycle response timing, clear/reset aborts and key hold.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         clear;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_rvalid;
  logic [127:0] rk_data;
  logic         rk_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0    = 0;

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           stamp;
    int           idx;
  } rd_t;
  rd_t sbq[$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_sched_ctrl #(.NR(10), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .clear      (clear),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_rvalid  (rk_rvalid),
    .rk_data    (rk_data),
    .rk_err     (rk_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-response checker: pops the oldest expected response and checks timing too
  always @(negedge clk) begin
    rd_t e;
    if (rk_rvalid === 1'b1) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: rk_rvalid=1 with no request outstanding at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        if (rk_err !== e.err || rk_data !== e.data || cyc != e.stamp + 1) begin
          fails++;
          $display("FAIL rd_idx%0d: got err=%b data=%h cyc=%0d, want err=%b data=%h cyc=%0d",
                   e.idx, rk_err, rk_data, cyc, e.err, e.data, e.stamp + 1);
        end
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].stamp + 1) begin
      e = sbq.pop_front();
      tests++;
      fails++;
      $display("FAIL rd_missing_idx%0d: no rk_rvalid at cycle %0d", e.idx, e.stamp + 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    rk_req = 1'b0;
  endtask

  // Issue a one-cycle read and record the response the spec requires
  task automatic rd(input int idx, input logic exp_err, input logic [127:0] exp_d);
    rd_t e;
    rk_req  = 1'b1;
    rk_idx  = 4'(idx);
    e.err   = exp_err;
    e.data  = exp_d;
    e.stamp = cyc;
    e.idx   = idx;
    sbq.push_back(e);
  endtask

  task automatic accept(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: done not seen within 30 cycles", name);
    end else if (cyc - e0 != 10) begin
      fails++;
      $display("FAIL %s_latency: done %0d cycles after accept, want 10", name, cyc - e0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in = '0; key_valid = 1'b0; clear = 1'b0; rk_req = 1'b0; rk_idx = '0;
    tick(); tick();
    tests++;
    if ({key_ready, busy, keys_valid, done, rk_rvalid, rk_err} !== 6'b100000 || rk_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy/busy/kv/done/rv/err=%b data=%h, want 100000 and 0",
               {key_ready, busy, keys_valid, done, rk_rvalid, rk_err}, rk_data);
    end
    rst_n = 1'b1;
    tick();
    rd(0, 1'b1, '0);
    tick();
  endtask

  task automatic test_fips();
    accept(FIPS_KEY);
    tests++;
    if ({key_ready, busy, keys_valid} !== 3'b010) begin
      fails++;
      $display("FAIL fips_expand_flags: rdy/busy/kv=%b, want 010", {key_ready, busy, keys_valid});
    end
    tick(); rd(3, 1'b1, '0);           // sampled at E0+2: not yet written
    tick(); rd(3, 1'b1, '0);           // sampled at E0+3: written this edge
    tick(); rd(3, 1'b0, fips_rk[3]);   // sampled at E0+4: available
    tick(); rd(11, 1'b1, '0);          // index beyond NR
    tick(); rd(0, 1'b0, FIPS_KEY);
    tick();
    wait_done("fips");
    tests++;
    if (keys_valid !== 1'b1) begin
      fails++;
      $display("FAIL fips_kv_at_done: keys_valid=%b, want 1", keys_valid);
    end
    tick();
    tests++;
    if ({done, keys_valid, key_ready, busy} !== 4'b0110) begin
      fails++;
      $display("FAIL fips_after_done: done/kv/rdy/busy=%b, want 0110", {done, keys_valid, key_ready, busy});
    end
    for (int i = 0; i <= 10; i++) begin
      rd(i, 1'b0, fips_rk[i]);
      tick();
    end
  endtask

  task automatic test_hold_second_key();
    int rdy_seen;
    int n;
    key_valid = 1'b1;
    key_in    = FIPS_KEY;
    tick();
    e0 = cyc;
    key_in = '0;
    rdy_seen = 0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      if (key_ready !== 1'b0) rdy_seen++;
      tick();
      n++;
    end
    tests++;
    if (rdy_seen != 0 || cyc - e0 != 10) begin
      fails++;
      $display("FAIL hold_expand: key_ready high %0d cycles, done after %0d, want 0 and 10", rdy_seen, cyc - e0);
    end
    tests++;
    if ({key_ready, keys_valid} !== 2'b11) begin
      fails++;
      $display("FAIL hold_ready: rdy/kv=%b, want 11", {key_ready, keys_valid});
    end
    tick();
    e0 = cyc;
    key_valid = 1'b0;
    tests++;
    if ({keys_valid, busy} !== 2'b01) begin
      fails++;
      $display("FAIL hold_second_accept: kv/busy=%b, want 01", {keys_valid, busy});
    end
    rd(5, 1'b1, '0);
    tick();
    wait_done("zero");
    rd(0, 1'b0, '0);   tick();
    rd(1, 1'b0, ZK1);  tick();
    rd(2, 1'b0, ZK2);  tick();
    rd(10, 1'b0, ZK10); tick();
  endtask

  task automatic test_clear_mid();
    int done_seen;
    accept(FIPS_KEY);
    tick(); tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if ({busy, key_ready, keys_valid} !== 3'b010) begin
      fails++;
      $display("FAIL clear_flags: busy/rdy/kv=%b, want 010", {busy, key_ready, keys_valid});
    end
    rd(0, 1'b1, '0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++;
      $display("FAIL clear_no_done: done/busy seen high %0d cycles, want 0", done_seen);
    end
  endtask

  task automatic test_clear_and_key();
    clear     = 1'b1;
    key_valid = 1'b1;
    key_in    = FIPS_KEY;
    tick();
    clear     = 1'b0;
    key_valid = 1'b0;
    tests++;
    if ({busy, key_ready, keys_valid} !== 3'b010) begin
      fails++;
      $display("FAIL clear_vs_key: busy/rdy/kv=%b, want 010", {busy, key_ready, keys_valid});
    end
    rd(0, 1'b1, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    accept(FIPS_KEY);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({key_ready, busy, keys_valid, done, rk_rvalid, rk_err} !== 6'b100000 || rk_data !== '0) begin
      fails++;
      $display("FAIL reset_mid: rdy/busy/kv/done/rv/err=%b data=%h, want 100000 and 0",
               {key_ready, busy, keys_valid, done, rk_rvalid, rk_err}, rk_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rd(10, 1'b1, '0);
    tick();
    accept(FIPS_KEY);
    wait_done("after_reset");
    rd(10, 1'b0, fips_rk[10]); tick();
    rd(4, 1'b0, fips_rk[4]);   tick();
  endtask

  initial begin
    test_reset();
    test_fips();
    test_hold_second_key();
    test_clear_mid();
    test_clear_and_key();
    test_reset_mid();
    tick();
    tick();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL rd_drain: %0d responses outstanding, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
